// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode classes, flag/condition types and flag update mask decode
package alu_pkg;
  localparam logic [1:0] OP_ARITH = 2'b00;
  localparam logic [1:0] OP_SHIFT = 2'b01;
  localparam logic [1:0] OP_LOGIC = 2'b10;
  localparam logic [4:0] OP_NEG   = 5'b11110;
  localparam logic [4:0] OP_INT   = 5'b11010;
  typedef enum logic [3:0] {EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV} cond_t;
  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } flags_t;
  typedef enum logic [1:0] {RUN, SAVE, ISR, REST} flag_fsm_t;
  // returns {vc_update, nz_update}; in the 11xxx group only bit 2 separates N/Z-only from no-update
  function automatic logic [1:0] upd_mask(input logic [4:0] op);
    return (op[4:3] == OP_ARITH || op[4:3] == OP_SHIFT) ? 2'b11 :
           (op[4:3] == OP_LOGIC)                        ? 2'b01 :
           (op == OP_NEG || op == OP_INT)               ? 2'b11 :
           op[2]                                        ? 2'b01 : 2'b00;
  endfunction
endpackage

// File: rtl/cond_eval.sv
// cond_eval: branch condition evaluation on stored flags
module cond_eval
  import alu_pkg::*;
(
  input  flags_t flags,
  input  cond_t  cond,
  output logic   cond_true
);
  // one result per condition code, signed comparisons via N==V
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      EQ: cond_true = flags.z;
      NE: cond_true = !flags.z;
      CS: cond_true = flags.c;
      CC: cond_true = !flags.c;
      MI: cond_true = flags.n;
      PL: cond_true = !flags.n;
      VS: cond_true = flags.v;
      VC: cond_true = !flags.v;
      HI: cond_true = flags.c && !flags.z;
      LS: cond_true = !flags.c || flags.z;
      GE: cond_true = flags.n == flags.v;
      LT: cond_true = flags.n != flags.v;
      GT: cond_true = !flags.z && (flags.n == flags.v);
      LE: cond_true = flags.z || (flags.n != flags.v);
      AL: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_flag_unit.sv
// alu_flag_unit: V/C/N/Z flag register, branch conditions, interrupt save/restore (optional STICKY_V_EN sticky overflow)
module alu_flag_unit
  import alu_pkg::*;
#(
  parameter int NFLAGS = 4,
  parameter int COND_W = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              V,
  input  logic              C,
  input  logic              N,
  input  logic              Z,
  input  logic [4:0]        OpCode,
  input  logic              FlagWe,
  input  logic [COND_W-1:0] CondCode,
  output logic              CondTrue,
  output logic [NFLAGS-1:0] Flags,
  output logic              CIn,
  input  logic              IntSave,
  input  logic              IntRest,
  output logic              IntAck,
  output logic              InIsr
`ifdef STICKY_V_EN
  ,
  input  logic              StickyClr,
  output logic              StickyV
`endif
);
  if (NFLAGS != $bits(flags_t) || COND_W != $bits(cond_t)) begin : g_bad_cfg
    $error("alu_flag_unit: NFLAGS/COND_W must match alu_pkg types");
  end
  flags_t    flags_q, flags_d, shadow_q, shadow_d;
  flag_fsm_t state_q, state_d;
  logic      vc_upd, nz_upd;
  // flag writes masked by opcode class; a restore overrides any same-cycle write
  always_comb begin
    {vc_upd, nz_upd} = upd_mask(OpCode);
    flags_d = flags_q;
    if (FlagWe && vc_upd) {flags_d.v, flags_d.c} = {V, C};
    if (FlagWe && nz_upd) {flags_d.n, flags_d.z} = {N, Z};
    if (state_q == REST) flags_d = shadow_q;
    shadow_d = (state_q == SAVE) ? flags_q : shadow_q;
    state_d  = (state_q == RUN)  ? (IntSave ? SAVE : RUN) :
               (state_q == SAVE) ? ISR :
               (state_q == ISR)  ? (IntRest ? REST : ISR) : RUN;
  end
  // flag, shadow and handshake state registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      flags_q  <= '0;
      shadow_q <= '0;
      state_q  <= RUN;
    end else begin
      flags_q  <= flags_d;
      shadow_q <= shadow_d;
      state_q  <= state_d;
    end
  end
  assign Flags  = flags_q;
  assign CIn    = flags_q.c;
  assign IntAck = (state_q == SAVE) || (state_q == REST);
  assign InIsr  = (state_q == ISR);
  cond_eval u_cond_eval (
    .flags    (flags_q),
    .cond     (cond_t'(CondCode)),
    .cond_true(CondTrue)
  );
`ifdef STICKY_V_EN
  logic sticky_q, sticky_d;
  // sticky overflow: set by any committed V=1, clear has priority
  always_comb begin
    sticky_d = !StickyClr && (sticky_q || (FlagWe && vc_upd && V && state_q != REST));
  end
  // sticky overflow register, not part of the saved context
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) sticky_q <= 1'b0;
    else sticky_q <= sticky_d;
  end
  assign StickyV = sticky_q;
`endif
endmodule
